// File: rtl/code_defs_pkg.sv
// Shared XGMII / RS code points and MAC framing constants.
// Also holds the small helpers used by the receive MAC.
package code_defs_pkg;

  localparam logic [7:0]  RS_START      = 8'hFB;
  localparam logic [7:0]  RS_TERM       = 8'hFD;
  localparam logic [7:0]  MAC_PRE_BYTE  = 8'h55;
  localparam logic [7:0]  MAC_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [2:0] keep_bytes(input logic [3:0] k);
    return {2'b00, k[0]} + {2'b00, k[1]} + {2'b00, k[2]} + {2'b00, k[3]};
  endfunction

endpackage

// File: rtl/crc32_32b.sv
// Combinational reflected CRC-32 update over up to four bytes.
// Lane 0 is consumed first, each byte LSB first.
module crc32_32b
  import code_defs_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  input  logic [3:0]  byte_en,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  logic [31:0] acc;

  always_comb begin
    acc = crc_in;
    for (int unsigned lane = 0; lane < 4; lane++) begin
      if (byte_en[lane]) begin
        for (int unsigned b = 0; b < 8; b++) begin
          if (acc[0] ^ data[lane*8 + b]) acc = (acc >> 1) ^ POLY_REFL;
          else                           acc = acc >> 1;
        end
      end
    end
  end

  assign crc_out = acc;

endmodule

// File: rtl/mac_rx.sv
// Receive MAC: strips preamble/SFD from 32-bit XGMII and emits frame bytes
// on a non-backpressured AXI-Stream with FCS/length/control error flagging.
module mac_rx
  import code_defs_pkg::*;
#(
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_xgmii_rxd,
  input  logic [3:0]  i_xgmii_rxc,
  input  logic        i_xgmii_valid,
  input  logic [3:0]  i_term_loc,
  output logic [31:0] o_axis_tdata,
  output logic [3:0]  o_axis_tkeep,
  output logic        o_axis_tvalid,
  output logic        o_axis_tlast,
  output logic        o_axis_tuser,
  output logic        o_frame_good,
  output logic        o_frame_bad
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t      state;
  logic [31:0] hold_data;
  logic [3:0]  hold_keep;
  logic        hold_vld;
  logic        hold_last;
  logic [31:0] crc;
  logic [31:0] crc_nxt;
  logic [15:0] len;
  logic [15:0] len_nxt;
  logic [16:0] len_sum;
  logic [3:0]  in_keep;
  logic        ctl_err;
  logic        frame_err;
  logic        end_err;
  logic        is_start;
  logic        is_sfd;

  // With a one-hot terminate at lane k, (1<<k)-1 is simply term_loc-1.
  assign in_keep  = (i_term_loc == 4'h0) ? 4'hF : i_term_loc - 4'd1;
  assign ctl_err  = (i_term_loc == 4'h0) ? (i_xgmii_rxc != 4'h0)
                                         : ((i_xgmii_rxc & in_keep) != 4'h0);
  assign is_start = (i_xgmii_rxc == 4'b0001) &&
                    (i_xgmii_rxd == {{3{MAC_PRE_BYTE}}, RS_START});
  assign is_sfd   = (i_xgmii_rxc == 4'h0) &&
                    (i_xgmii_rxd == {MAC_SFD, {3{MAC_PRE_BYTE}}});

  assign len_sum  = {1'b0, len} + {14'b0, keep_bytes(in_keep)};
  assign len_nxt  = len_sum[16] ? '1 : len_sum[15:0];

  // crc/len already cover the held word, so they describe the whole frame at tlast.
  assign frame_err = (crc != CRC32_RESIDUE) ||
                     (len < 16'(MIN_FRAME_BYTES)) ||
                     (len > 16'(MAX_FRAME_BYTES));
  assign end_err   = ctl_err | frame_err;

  crc32_32b u_crc (
    .crc_in  (crc),
    .data    (i_xgmii_rxd),
    .byte_en (in_keep),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      hold_data     <= '0;
      hold_keep     <= '0;
      hold_vld      <= 1'b0;
      hold_last     <= 1'b0;
      crc           <= '1;
      len           <= '0;
      o_axis_tdata  <= '0;
      o_axis_tkeep  <= '0;
      o_axis_tvalid <= 1'b0;
      o_axis_tlast  <= 1'b0;
      o_axis_tuser  <= 1'b0;
      o_frame_good  <= 1'b0;
      o_frame_bad   <= 1'b0;
    end else begin
      o_axis_tvalid <= 1'b0;
      o_axis_tkeep  <= '0;
      o_axis_tlast  <= 1'b0;
      o_axis_tuser  <= 1'b0;
      o_frame_good  <= 1'b0;
      o_frame_bad   <= 1'b0;

      if (hold_vld && hold_last) begin
        o_axis_tvalid <= 1'b1;
        o_axis_tdata  <= hold_data;
        o_axis_tkeep  <= hold_keep;
        o_axis_tlast  <= 1'b1;
        o_axis_tuser  <= frame_err;
        o_frame_good  <= ~frame_err;
        o_frame_bad   <= frame_err;
        hold_vld      <= 1'b0;
        hold_last     <= 1'b0;
        hold_keep     <= '0;
      end

      if (i_xgmii_valid) begin
        case (state)
          IDLE: begin
            if (is_start) begin
              state <= PREAMBLE;
              crc   <= '1;
              len   <= '0;
            end
          end
          PREAMBLE: state <= is_sfd ? DATA : IDLE;
          DATA: begin
            if (ctl_err || i_term_loc[0]) begin
              o_axis_tvalid <= 1'b1;
              o_axis_tdata  <= hold_data;
              o_axis_tkeep  <= hold_keep;
              o_axis_tlast  <= 1'b1;
              o_axis_tuser  <= end_err;
              o_frame_good  <= ~end_err;
              o_frame_bad   <= end_err;
              hold_vld      <= 1'b0;
              hold_keep     <= '0;
              state         <= IDLE;
            end else begin
              if (hold_vld) begin
                o_axis_tvalid <= 1'b1;
                o_axis_tdata  <= hold_data;
                o_axis_tkeep  <= hold_keep;
              end
              hold_data <= i_xgmii_rxd;
              hold_keep <= in_keep;
              hold_vld  <= 1'b1;
              hold_last <= (i_term_loc != 4'h0);
              crc       <= crc_nxt;
              len       <= len_nxt;
              if (i_term_loc != 4'h0) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mac_rx.md
Name: mac_rx

Overview:
- Receive MAC stage directly downstream of the PCS RX XGMII output, clocked in the PCS RX clock domain (no CDC).
- Consumes the 32-bit XGMII words, their valid qualifier and precomputed terminate-lane flags.
- Detects start and preamble/SFD, and emits frame bytes (destination address through FCS inclusive) as a non-backpressurable AXI-Stream.
- Checks FCS via the CRC-32 residue, checks length bounds and flags bad frames on the last beat.

Parameters:
- MIN_FRAME_BYTES, 64, minimum legal frame length including FCS.
- MAX_FRAME_BYTES, 1518, maximum legal frame length including FCS.

Ports:
- i_clk  in  1  RX clock (same clock as the PCS RX side).
- i_reset_n  in  1  asynchronous active-low reset.
- i_xgmii_rxd  in  32  XGMII data, lane 0 = bits 7:0.
- i_xgmii_rxc  in  4  XGMII control flags, one per lane.
- i_xgmii_valid  in  1  word qualifier; low = PCS pause cycle, word ignored.
- i_term_loc  in  4  one-hot lane holding RS_TERM (qualified by valid).
- o_axis_tdata  out  32  frame bytes, byte 0 = bits 7:0.
- o_axis_tkeep  out  4  contiguous from lane 0; not 4'hF only on tlast.
- o_axis_tvalid  out  1  beat valid; there is no tready.
- o_axis_tlast  out  1  last beat of frame.
- o_axis_tuser  out  1  frame error; meaningful only with tlast.
- o_frame_good  out  1  one-cycle pulse concurrent with a good tlast.
- o_frame_bad  out  1  one-cycle pulse concurrent with an errored tlast.

Behaviour:
- Reset: async assert clears all outputs to 0 and forces state to IDLE, hold register empty and CRC to 32'hFFFFFFFF. Reset mid-frame discards the frame; no tlast is emitted.
- Words with i_xgmii_valid=0 change no state. Hold and pending outputs still drain per the rules below.
- FSM, advancing only on valid words:
  - IDLE -> PREAMBLE when rxc=4'b0001, byte0=RS_START (8'hFB) and bytes1-3=8'h55.
  - PREAMBLE -> DATA when rxc=0 and the word is 32'hD5555555. Otherwise -> IDLE; the frame is dropped silently with no output.
  - DATA, term_loc=0 and rxc=0: word enters the hold register (keep 4'hF). The previous hold word is emitted as a non-last beat.
  - DATA, term_loc lane k (one-hot): lanes <k are data and must have rxc=0.
    - k=0: the hold word is emitted as tlast with keep 4'hF.
    - k>0: the hold word is emitted non-last. The current word enters hold with keep = (1<<k)-1 and a last flag. The last-flagged hold is emitted on the next cycle regardless of valid.
    - Both cases -> IDLE.
  - DATA, any rxc bit set with term_loc=0, or rxc set in a lane below term: control error. The hold word is emitted as tlast with tuser=1 (keep as held) -> IDLE. If hold is empty, a tlast beat with keep=0 and tuser=1 is emitted.
- Latency: a data word accepted at cycle t appears on o_axis_* at t+2 at the earliest (hold stage plus output register). Order is always preserved.
- CRC:
  - Reflected CRC-32 (poly 0x04C11DB7), init 32'hFFFFFFFF, no final XOR, byte-enabled per lane.
  - Updated over every word entering hold, using its keep.
  - Good FCS is register == 32'hDEBB20E3 after the last byte.
  - tuser on the tlast beat uses the CRC including that beat's bytes, computed combinationally at output-register load.
- Length:
  - 16-bit byte counter, saturating at 16'hFFFF, counting kept bytes.
  - tuser = crc_bad | ctl_err | (len < MIN_FRAME_BYTES) | (len > MAX_FRAME_BYTES).
  - Over-length frames are still passed through in full.
- o_frame_good = tlast & tvalid & ~tuser. o_frame_bad = tlast & tvalid & tuser. Both are cleared the next cycle.
- A start word arriving while the last-flagged hold drains: the new frame is accepted normally with no loss (hold drains first).

Decomposition:
- code_defs_pkg (existing): RS_START, RS_TERM. Add MAC_PRE_BYTE 8'h55, MAC_SFD 8'hD5, CRC32_POLY and CRC32_RESIDUE 32'hDEBB20E3.
- FSM state enum local to mac_rx.
- One sub-module, crc32_32b: combinational next-CRC over 32-bit data with a 4-bit byte-enable.

Test Plan:
- 64-byte good frame (60 payload bytes incrementing from 8'h00, plus correct FCS), term at lane 0 -> 16 beats, last keep 4'hF, tuser=0, o_frame_good pulse.
- Frames of 65/66/67 bytes (term lanes 1/2/3) -> last keep 4'h1/4'h3/4'h7, tuser=0. Byte stream matches the input exactly.
- 64-byte frame with FCS bit 0 flipped -> tlast tuser=1, o_frame_bad pulse, byte data unchanged.
- Good 64-byte frame with i_xgmii_valid low every 32nd cycle -> output identical to the no-gap run.
- Error cases:
  - Control byte 8'hFE (rxc set) in data word 5 -> tlast on the held word with tuser=1, FSM returns to IDLE, next frame received good.
  - 60-byte frame with valid FCS -> tuser=1 (short).
  - Bad SFD (32'hD4555555) -> no output at all.
- Back-to-back good frames separated by one idle word, with i_reset_n pulsed low mid-third-frame -> two good tlasts, all outputs immediately 0 on reset, no third tlast.
